ds18b20_responder: RTL and testbench

- 1-Wire slave that emulates a DS18B20 on the shared open-drain dq line. It is the target end for the team's DS18B20 bus master, used in simulation and on-board loopback.
- Answers reset with a presence pulse. Accepts Skip ROM (0xCC), Convert T (0x44) and Read Scratchpad (0xBE).
- Serves a 9-byte scratchpad whose temperature field is sampled from the temp_raw input at the end of each conversion.

---
 rtl/ds18b20_responder.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_ds18b20_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ds18b20_responder.sv
// ds18b20_responder
// Emulates a DS18B20 1-Wire slave on an open-drain dq line. It sends a presence
// pulse after a bus reset and accepts Skip ROM (0xCC), then Convert T (0x44) or
// Read Scratchpad (0xBE). The temperature field is loaded from temp_raw when a
// conversion ends.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   dq           1-Wire line; this block only drives 0 or releases it (z)
//   temp_raw     signed temperature in 1/16 degC, sampled at end of conversion
//   conv_busy    high while a conversion is running
//   cmd_strobe   one-cycle pulse when a function command byte is accepted
//   cmd_byte     last received command byte (ROM or function)
//   presence_cnt number of presence pulses issued (wraps)
//
// Optional build macro: DS18B20_RESP_CRC_EN. When it is defined, scratchpad
// byte 8 is the Dallas CRC8 of bytes 0..7. When it is not defined, byte 8 is
// 0x00 and no CRC logic is built.

module ds18b20_responder #(
    parameter int unsigned SYSCLK_HZ   = 25_000_000,
    parameter int unsigned T_RSTMIN_US = 400,
    parameter int unsigned T_PDHIGH_US = 30,
    parameter int unsigned T_PDLOW_US  = 120,
    parameter int unsigned T_SAMPLE_US = 30,
    parameter int unsigned T_RDLOW_US  = 30,
    parameter int unsigned T_CONV_US   = 750_000
) (
    input  logic        clk,
    input  logic        rst_n,
    inout  logic        dq,
    input  logic [15:0] temp_raw,
    output logic        conv_busy,
    output logic        cmd_strobe,
    output logic [7:0]  cmd_byte,
    output logic [7:0]  presence_cnt
);

    localparam int unsigned CYC_US   = SYSCLK_HZ / 1_000_000;
    localparam int unsigned DIV_W    = (CYC_US > 1) ? $clog2(CYC_US) : 1;
    localparam int unsigned CONV_CYC = T_CONV_US * CYC_US;
    localparam int unsigned CONV_W   = $clog2(CONV_CYC + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CYC_US - 1);
    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_CYC - 1);
    localparam logic [15:0]       RSTMIN    = 16'(T_RSTMIN_US);
    localparam logic [7:0]        PDH       = 8'(T_PDHIGH_US);
    localparam logic [7:0]        PDL       = 8'(T_PDLOW_US);
    localparam logic [7:0]        SMP       = 8'(T_SAMPLE_US);
    localparam logic [7:0]        RDL       = 8'(T_RDLOW_US);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PD_WAIT  = 3'd1;
    localparam logic [2:0] PD_LOW   = 3'd2;
    localparam logic [2:0] ROM_CMD  = 3'd3;
    localparam logic [2:0] FUNC_CMD = 3'd4;
    localparam logic [2:0] CONV     = 3'd5;
    localparam logic [2:0] TX       = 3'd6;

    logic [2:0]        state;
    logic              drive_low;
    logic              dq_m, dq_s, dq_p;
    logic              dq_fall, dq_rise, slot_start, rst_det;
    logic [DIV_W-1:0]  us_div;
    logic              us_tick;
    logic [15:0]       low_us;
    logic [7:0]        slot_us;
    logic              slot_live;
    logic              sample_ev;
    logic [7:0]        rx_sr;
    logic [7:0]        rx_byte;
    logic [2:0]        bit_cnt;
    logic              rx_done;
    logic              conv_go;
    logic [3:0]        byte_idx;
    logic [2:0]        bit_idx;
    logic [7:0]        sp_byte;
    logic              tx_bit;
    logic [CONV_W-1:0] conv_cnt;
    logic [15:0]       temp_q;
`ifdef DS18B20_RESP_CRC_EN
    logic [7:0]        crc_q;
    logic              crc_fb;
`endif

    assign dq = drive_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq_m <= 1'b1;
            dq_s <= 1'b1;
            dq_p <= 1'b1;
        end else begin
            dq_m <= dq;
            dq_s <= dq_m;
            dq_p <= dq_s;
        end
    end

    assign dq_fall = dq_p & ~dq_s;
    assign dq_rise = ~dq_p & dq_s;
    // Falls caused by our own drive are not slots.
    assign slot_start = dq_fall & ~drive_low;
    assign rst_det    = dq_rise & (low_us >= RSTMIN);
    assign us_tick    = (us_div == DIV_LAST);

    // us prescaler, re-phased at every slot edge and at reset release so that
    // all timing counts whole us from the detected edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            us_div <= '0;
        else if (slot_start || rst_det || us_tick)
            us_div <= '0;
        else
            us_div <= us_div + 1'b1;
    end

    // Low width of the bus as driven by someone else; held until the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            low_us <= '0;
        else if (dq_s)
            low_us <= '0;
        else if (us_tick && !drive_low && (low_us != '1))
            low_us <= low_us + 1'b1;
    end

    assign sample_ev = slot_live && (slot_us == SMP);
    assign rx_byte   = {dq_s, rx_sr[7:1]};
    assign rx_done   = sample_ev && (bit_cnt == 3'd7) && !rst_det;
    assign conv_go   = (state == FUNC_CMD) && rx_done && (rx_byte == 8'h44);

    always_comb begin
        sp_byte = 8'hFF;
        case (byte_idx)
            4'd0: sp_byte = temp_q[7:0];
            4'd1: sp_byte = temp_q[15:8];
            4'd2: sp_byte = 8'h4B;
            4'd3: sp_byte = 8'h46;
            4'd4: sp_byte = 8'h7F;
            4'd5: sp_byte = 8'hFF;
            4'd6: sp_byte = 8'h0C;
            4'd7: sp_byte = 8'h10;
`ifdef DS18B20_RESP_CRC_EN
            4'd8: sp_byte = crc_q;
`else
            4'd8: sp_byte = 8'h00;
`endif
            default: sp_byte = 8'hFF;
        endcase
    end

    always_comb begin
        tx_bit = 1'b1;
        if (state == TX)
            tx_bit = sp_byte[bit_idx];
        else if (state == CONV)
            tx_bit = ~conv_busy;
    end

`ifdef DS18B20_RESP_CRC_EN
    assign crc_fb = crc_q[0] ^ tx_bit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            drive_low    <= 1'b0;
            slot_us      <= '0;
            slot_live    <= 1'b0;
            rx_sr        <= '0;
            bit_cnt      <= '0;
            byte_idx     <= '0;
            bit_idx      <= '0;
            cmd_byte     <= '0;
            cmd_strobe   <= 1'b0;
            presence_cnt <= '0;
`ifdef DS18B20_RESP_CRC_EN
            crc_q        <= '0;
`endif
        end else begin
            cmd_strobe <= 1'b0;
            if (us_tick && (slot_us != '1))
                slot_us <= slot_us + 1'b1;
            if (sample_ev)
                slot_live <= 1'b0;
            if (slot_start) begin
                slot_us   <= '0;
                slot_live <= 1'b1;
            end

            case (state)
                PD_WAIT: begin
                    if (slot_us == PDH) begin
                        drive_low <= 1'b1;
                        slot_us   <= '0;
                        state     <= PD_LOW;
                    end
                end
                PD_LOW: begin
                    if (slot_us == PDL) begin
                        drive_low    <= 1'b0;
                        presence_cnt <= presence_cnt + 1'b1;
                        bit_cnt      <= '0;
                        state        <= ROM_CMD;
                    end
                end
                ROM_CMD, FUNC_CMD: begin
                    if (sample_ev) begin
                        rx_sr   <= rx_byte;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            cmd_byte <= rx_byte;
                            if (state == ROM_CMD) begin
                                state <= (rx_byte == 8'hCC) ? FUNC_CMD : IDLE;
                            end else begin
                                cmd_strobe <= 1'b1;
                                if (rx_byte == 8'h44) begin
                                    state <= CONV;
                                end else if (rx_byte == 8'hBE) begin
                                    byte_idx <= '0;
                                    bit_idx  <= '0;
`ifdef DS18B20_RESP_CRC_EN
                                    crc_q    <= '0;
`endif
                                    state    <= TX;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end
                    end
                end
                CONV, TX: begin
                    if (drive_low && (slot_us == RDL))
                        drive_low <= 1'b0;
                    if (slot_start) begin
                        if (!tx_bit)
                            drive_low <= 1'b1;
                        if ((state == TX) && (byte_idx != 4'd9)) begin
`ifdef DS18B20_RESP_CRC_EN
                            if (byte_idx < 4'd8)
                                crc_q <= {1'b0, crc_q[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
`endif
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == 3'd7)
                                byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            // A bus reset overrides any state and drops a partial byte.
            if (rst_det) begin
                state      <= PD_WAIT;
                drive_low  <= 1'b0;
                slot_us    <= '0;
                slot_live  <= 1'b0;
                bit_cnt    <= '0;
                cmd_strobe <= 1'b0;
            end
        end
    end

    // Conversion timer runs in raw clock cycles, independent of slot activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_busy <= 1'b0;
            conv_cnt  <= '0;
            temp_q    <= 16'h0550;
        end else if (conv_go) begin
            conv_busy <= 1'b1;
            conv_cnt  <= '0;
        end else if (conv_busy) begin
            if (conv_cnt == CONV_LAST) begin
                conv_busy <= 1'b0;
                temp_q    <= temp_raw;
            end else begin
                conv_cnt <= conv_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ds18b20_responder.sv
`timescale 1ns/1ps
module tb_ds18b20_responder;

    localparam int unsigned US = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_low = 1'b0;
    logic [15:0] temp_raw = 16'h0191;
    logic        conv_busy;
    logic        cmd_strobe;
    logic [7:0]  cmd_byte;
    logic [7:0]  presence_cnt;
    wire         dq;

    assign dq = m_low ? 1'b0 : 1'bz;
    pullup (dq);

    ds18b20_responder #(
        .SYSCLK_HZ(2_000_000),
        .T_CONV_US(2000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .dq(dq),
        .temp_raw(temp_raw),
        .conv_busy(conv_busy),
        .cmd_strobe(cmd_strobe),
        .cmd_byte(cmd_byte),
        .presence_cnt(presence_cnt)
    );

    always #250 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned strobe_cnt = 0;
    int unsigned busy_cyc = 0;
    int unsigned exp_pres = 0;
    int unsigned exp_strobe = 0;

    always @(posedge clk) if (cmd_strobe) strobe_cnt++;
    always @(negedge clk) if (conv_busy) busy_cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] crc8_dallas(input logic [63:0] v);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < 64; i++) begin
            fb = c[0] ^ v[i];
            c  = c >> 1;
            if (fb) c = c ^ 8'h8C;
        end
        return c;
    endfunction

    task automatic wr_bit(input logic b);
        m_low = 1'b1;
        #((b ? 2 : 60) * US);
        m_low = 1'b0;
        #((b ? 68 : 10) * US);
    endtask

    task automatic wr_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) wr_bit(v[i]);
    endtask

    task automatic rd_bit(output logic b);
        m_low = 1'b1;
        #(2 * US);
        m_low = 1'b0;
        #(11 * US);
        b = dq;
        #(57 * US);
    endtask

    task automatic rd_byte(output logic [7:0] v);
        logic b;
        for (int i = 0; i < 8; i++) begin
            rd_bit(b);
            v[i] = b;
        end
    endtask

    task automatic bus_reset(input int unsigned low_us);
        m_low = 1'b1;
        #(low_us * US);
        m_low = 1'b0;
        #(25 * US);  check("pd_before", 32'(dq), 32'd1);
        #(15 * US);  check("pd_start", 32'(dq), 32'd0);
        #(105 * US); check("pd_hold", 32'(dq), 32'd0);
        #(20 * US);  check("pd_end", 32'(dq), 32'd1);
        exp_pres++;
        check("presence_cnt", 32'(presence_cnt), exp_pres);
        #(235 * US);
    endtask

    initial begin
        #(150_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] rb;
        logic       b;
        logic [7:0] exp_sp [9];
        int unsigned b0;

        #(5 * US);
        rst_n = 1'b1;
        #(2 * US);
        check("rst_dq", 32'(dq), 32'd1);
        check("rst_conv_busy", 32'(conv_busy), 32'd0);
        check("rst_cmd_strobe", 32'(cmd_strobe), 32'd0);
        check("rst_cmd_byte", 32'(cmd_byte), 32'h00);
        check("rst_presence", 32'(presence_cnt), 32'd0);
        #(20 * US);

        // Power-on temperature before any conversion.
        bus_reset(480);
        wr_byte(8'hCC);
        wr_byte(8'hBE);
        exp_strobe++;
        check("strobe_be", strobe_cnt, exp_strobe);
        check("cmd_be", 32'(cmd_byte), 32'hBE);
        rd_byte(rb); check("por_b0", 32'(rb), 32'h50);
        rd_byte(rb); check("por_b1", 32'(rb), 32'h05);

        // Convert T with read slots during and after the conversion.
        bus_reset(480);
        b0 = busy_cyc;
        wr_byte(8'hCC);
        wr_byte(8'h44);
        exp_strobe++;
        check("strobe_44", strobe_cnt, exp_strobe);
        check("cmd_44", 32'(cmd_byte), 32'h44);
        check("busy_set", 32'(conv_busy), 32'd1);
        #(60 * US);
        rd_bit(b); check("rd_busy", 32'(b), 32'd0);
        for (int i = 0; i < 3000 && conv_busy; i++) #(US);
        check("conv_done", 32'(conv_busy), 32'd0);
        check("conv_cycles", busy_cyc - b0, 32'd4000);
        rd_bit(b); check("rd_done", 32'(b), 32'd1);

        // Full scratchpad read plus the trailing all-ones byte.
        exp_sp = '{8'h91, 8'h01, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h00};
`ifdef DS18B20_RESP_CRC_EN
        exp_sp[8] = crc8_dallas(64'h100CFF7F464B0191);
`endif
        bus_reset(480);
        wr_byte(8'hCC);
        wr_byte(8'hBE);
        exp_strobe++;
        for (int i = 0; i < 9; i++) begin
            rd_byte(rb);
            check($sformatf("sp_byte%0d", i), 32'(rb), 32'(exp_sp[i]));
        end
        rd_byte(rb); check("sp_after", 32'(rb), 32'hFF);

        // Unsupported ROM command leaves the slave idle.
        bus_reset(480);
        wr_byte(8'h33);
        check("cmd_33", 32'(cmd_byte), 32'h33);
        wr_byte(8'hCC);
        wr_byte(8'hBE);
        rd_byte(rb); check("idle_read", 32'(rb), 32'hFF);
        check("idle_strobe", strobe_cnt, exp_strobe);
        check("idle_cmd", 32'(cmd_byte), 32'h33);

        // Reset mid-byte discards the partial command.
        bus_reset(480);
        wr_byte(8'hCC);
        wr_bit(1'b0); wr_bit(1'b1); wr_bit(1'b1); wr_bit(1'b1);
        bus_reset(500);
        check("mid_strobe", strobe_cnt, exp_strobe);
        wr_byte(8'hCC);
        wr_byte(8'hBE);
        exp_strobe++;
        check("mid_strobe_be", strobe_cnt, exp_strobe);
        rd_byte(rb); check("mid_b0", 32'(rb), 32'h91);
        rd_byte(rb); check("mid_b1", 32'(rb), 32'h01);

        // Hardware reset during the presence pulse.
        m_low = 1'b1;
        #(480 * US);
        m_low = 1'b0;
        #(60 * US);
        check("pd_active", 32'(dq), 32'd0);
        rst_n = 1'b0;
        #1;
        check("hrst_dq", 32'(dq), 32'd1);
        check("hrst_presence", 32'(presence_cnt), 32'd0);
        check("hrst_cmd_byte", 32'(cmd_byte), 32'h00);
        check("hrst_busy", 32'(conv_busy), 32'd0);
        check("hrst_strobe", 32'(cmd_strobe), 32'd0);
        #(10 * US);
        rst_n = 1'b1;
        exp_pres = 0;
        #(300 * US);
        bus_reset(480);
        wr_byte(8'hCC);
        wr_byte(8'hBE);
        rd_byte(rb); check("hrst_b0", 32'(rb), 32'h50);
        rd_byte(rb); check("hrst_b1", 32'(rb), 32'h05);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
